// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions, used by triangle_dispatcher and
// rasterizer_unit.
//   WORDS_PER_TRI  - vertex RAM words per triangle (x1,y1,z1 .. x3,y3,z3)
//   FP_ONE         - float32 1.0
//   vertex_t       - {x,y,z} float32 triple, element 0 = x, 1 = y, 2 = z
//   launch_state_t - launch-engine FSM states
//   fetch_state_t  - fetch-engine FSM states
package gpu_pkg;

  localparam int unsigned WORDS_PER_TRI = 9;
  localparam logic [31:0] FP_ONE = 32'h3f800000;

  typedef logic [2:0][31:0] vertex_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_LAUNCH,
    L_WAIT,
    L_FINISH
  } launch_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_READ,
    F_FILL
  } fetch_state_t;

endpackage

// File: rtl/triangle_dispatcher_if.sv
// Vertex RAM read bus and rasterizer_unit handshake.
//   mem_rd/mem_addr  - read strobe and word address (dispatcher -> RAM)
//   mem_rdata        - read data, valid one cycle after mem_rd (RAM -> dispatcher)
//   p1/p2/p3, start  - triangle vertices and launch pulse (dispatcher -> rasterizer)
//   done             - rasterizer completion level (rasterizer -> dispatcher)
interface triangle_dispatcher_if
  import gpu_pkg::*;
#(
  parameter int unsigned MEM_AW = 8
);

  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  vertex_t           p1;
  vertex_t           p2;
  vertex_t           p3;
  logic              start;
  logic              done;

  modport master (
    output mem_rd, mem_addr, p1, p2, p3, start,
    input  mem_rdata, done
  );

  modport slave (
    input  mem_rd, mem_addr, p1, p2, p3, start,
    output mem_rdata, done
  );

endinterface

// File: rtl/tri_fetch_unit.sv
// Fetch engine: reads one triangle (9 words) from vertex RAM into a
// one-entry staging buffer whenever the buffer is free and triangles remain.
//   clk, areset         - clock, async active-high reset
//   frame_load          - accepted frame start; resets address, loads count
//   load_count          - clamped triangle count for the frame
//   mem_rd/mem_addr     - RAM read strobe/address
//   mem_rdata           - RAM data, one cycle after mem_rd
//   stg_valid/stg_take  - staging buffer handshake with the launch engine
//   stg_p1/p2/p3        - staged vertices
module tri_fetch_unit
  import gpu_pkg::*;
#(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              frame_load,
  input  logic [CNT_W-1:0]  load_count,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              stg_take,
  output logic              stg_valid,
  output vertex_t           stg_p1,
  output vertex_t           stg_p2,
  output vertex_t           stg_p3
);

  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_TRI - 1);

  fetch_state_t      state, state_next;
  logic [MEM_AW-1:0] addr;
  logic [3:0]        word_idx;
  logic              rd_q;
  logic [3:0]        rd_idx_q;
  logic [8:0][31:0]  stg_w;
  logic [CNT_W-1:0]  fetch_remaining;
  logic [CNT_W-1:0]  remaining_eff;
  logic              go;
  logic              last_capture;

  // Looking through frame_load and stg_take lets the first read issue the
  // cycle after frame_start, and a refetch issue the cycle after the take.
  assign remaining_eff = frame_load ? load_count : fetch_remaining;
  assign go            = (~stg_valid | stg_take) & (remaining_eff != '0);
  assign last_capture  = rd_q & (rd_idx_q == LAST_WORD);

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (go) state_next = F_READ;
      F_READ:  if (word_idx == LAST_WORD) state_next = F_FILL;
      F_FILL:  state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= F_IDLE;
    else        state <= state_next;
  end

  assign mem_rd   = (state == F_READ);
  assign mem_addr = addr;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      addr            <= '0;
      word_idx        <= '0;
      rd_q            <= 1'b0;
      rd_idx_q        <= '0;
      stg_w           <= '0;
      stg_valid       <= 1'b0;
      fetch_remaining <= '0;
    end else begin
      if (frame_load)  addr <= '0;
      else if (mem_rd) addr <= addr + 1'b1;

      word_idx <= mem_rd ? word_idx + 1'b1 : '0;
      rd_q     <= mem_rd;
      rd_idx_q <= word_idx;

      if (rd_q) stg_w[rd_idx_q] <= mem_rdata;

      if (last_capture)  stg_valid <= 1'b1;
      else if (stg_take) stg_valid <= 1'b0;

      if (frame_load)        fetch_remaining <= load_count;
      else if (last_capture) fetch_remaining <= fetch_remaining - 1'b1;
    end
  end

  assign stg_p1 = stg_w[2:0];
  assign stg_p2 = stg_w[5:3];
  assign stg_p3 = stg_w[8:6];

endmodule

// File: rtl/triangle_dispatcher.sv
// Triangle dispatcher: walks a triangle list in vertex RAM and launches each
// triangle on rasterizer_unit, prefetching the next one while it rasterizes.
//   clk (gpu_clk_150), areset - clock, async active-high reset
//   frame_start, tri_count    - begin a frame of tri_count triangles
//   busy, frame_done          - frame in progress / last triangle completed
//   bus                       - vertex RAM read port and rasterizer handshake
module triangle_dispatcher
  import gpu_pkg::*;
#(
  parameter int unsigned MAX_TRIS = 16,
  parameter int unsigned MEM_AW   = $clog2(MAX_TRIS * WORDS_PER_TRI),
  parameter int unsigned CNT_W    = $clog2(MAX_TRIS + 1)
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  frame_start,
  input  logic [CNT_W-1:0]      tri_count,
  output logic                  busy,
  output logic                  frame_done,
  triangle_dispatcher_if.master bus
);

  launch_state_t    l_state, l_next;
  logic             accept;
  logic [CNT_W-1:0] cnt_clamped;
  logic [CNT_W-1:0] launch_remaining;
  logic             busy_r;
  logic             done_q;
  logic             done_rise;
  logic             stg_valid;
  logic             stg_take;
  vertex_t          stg_p1, stg_p2, stg_p3;
  vertex_t          p1_r, p2_r, p3_r;

  assign accept      = frame_start & ~busy_r;
  assign cnt_clamped = (tri_count > CNT_W'(MAX_TRIS)) ? CNT_W'(MAX_TRIS) : tri_count;
  // A level left high by the previous triangle must not count as completion.
  assign done_rise   = bus.done & ~done_q;

  tri_fetch_unit #(
    .MEM_AW (MEM_AW),
    .CNT_W  (CNT_W)
  ) u_fetch (
    .clk        (clk),
    .areset     (areset),
    .frame_load (accept),
    .load_count (cnt_clamped),
    .mem_rd     (bus.mem_rd),
    .mem_addr   (bus.mem_addr),
    .mem_rdata  (bus.mem_rdata),
    .stg_take   (stg_take),
    .stg_valid  (stg_valid),
    .stg_p1     (stg_p1),
    .stg_p2     (stg_p2),
    .stg_p3     (stg_p3)
  );

  always_comb begin
    l_next   = l_state;
    stg_take = 1'b0;
    case (l_state)
      L_IDLE: begin
        if (accept && cnt_clamped == '0) begin
          l_next = L_FINISH;
        end else if (stg_valid) begin
          stg_take = 1'b1;
          l_next   = L_LAUNCH;
        end
      end
      L_LAUNCH: l_next = L_WAIT;
      L_WAIT: begin
        if (done_rise) l_next = (launch_remaining != '0) ? L_IDLE : L_FINISH;
      end
      L_FINISH: l_next = (accept && cnt_clamped == '0) ? L_FINISH : L_IDLE;
      default:  l_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) l_state <= L_IDLE;
    else        l_state <= l_next;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      launch_remaining <= '0;
      busy_r           <= 1'b0;
      done_q           <= 1'b0;
      p1_r             <= '0;
      p2_r             <= '0;
      p3_r             <= '0;
    end else begin
      done_q <= bus.done;

      if (accept)        launch_remaining <= cnt_clamped;
      else if (stg_take) launch_remaining <= launch_remaining - 1'b1;

      // Cleared on entry to L_FINISH so busy is already low in the
      // frame_done cycle.
      if (accept)                               busy_r <= (cnt_clamped != '0);
      else if (l_state == L_WAIT && l_next == L_FINISH) busy_r <= 1'b0;

      if (stg_take) begin
        p1_r <= stg_p1;
        p2_r <= stg_p2;
        p3_r <= stg_p3;
      end
    end
  end

  assign bus.start  = (l_state == L_LAUNCH);
  assign bus.p1     = p1_r;
  assign bus.p2     = p2_r;
  assign bus.p3     = p3_r;
  assign frame_done = (l_state == L_FINISH);
  assign busy       = busy_r;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed testbench for triangle_dispatcher: RAM model, simple rasterizer
// model, negedge monitor, hand-computed cycle/address/vertex expectations.
module tb_triangle_dispatcher;
  import gpu_pkg::*;

  localparam int unsigned MAX_TRIS = 16;
  localparam int unsigned MEM_AW   = 8;
  localparam int unsigned CNT_W    = 5;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             frame_start = 1'b0;
  logic [CNT_W-1:0] tri_count = '0;
  logic             busy;
  logic             frame_done;

  triangle_dispatcher_if #(.MEM_AW(MEM_AW)) bus ();

  triangle_dispatcher #(
    .MAX_TRIS (MAX_TRIS),
    .MEM_AW   (MEM_AW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .frame_start (frame_start),
    .tri_count   (tri_count),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [MAX_TRIS*WORDS_PER_TRI];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];

  bit   raster_auto = 1'b1;
  int   rast_delay  = 20;
  logic done_auto   = 1'b0;
  logic done_man    = 1'b0;
  assign bus.done = raster_auto ? done_auto : done_man;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor state
  int cyc = 0, cyc0 = 0, cd = 0;
  int rd_cnt, rd_first_cyc, rd_last_addr, rd9_cyc, addr_err;
  int st_cnt, pm_err, p_err, fd_cnt, fd_cyc, busy_cnt;
  bit fd_busy;
  int st_cyc [32];
  vertex_t first_p1, first_p2, first_p3, pp1, pp2, pp3;

  always @(posedge clk) cyc++;

  function automatic logic [287:0] exp_tri(input int n);
    logic [287:0] r = '0;
    if (n < int'(MAX_TRIS))
      for (int k = 0; k < 9; k++) r[k*32 +: 32] = ram[n*9 + k];
    return r;
  endfunction

  task automatic clr_mon();
    rd_cnt = 0; rd_first_cyc = -1; rd_last_addr = -1; rd9_cyc = -1; addr_err = 0;
    st_cnt = 0; pm_err = 0; p_err = 0; fd_cnt = 0; fd_cyc = -1; busy_cnt = 0; fd_busy = 1'b1;
  endtask

  always @(negedge clk) begin
    done_auto = 1'b0;
    if (areset) begin
      cd = 0;
    end else begin
      if (bus.mem_rd) begin
        if (rd_cnt == 0) rd_first_cyc = cyc - cyc0;
        if (bus.mem_addr == 8'd9) rd9_cyc = cyc - cyc0;
        if (int'(bus.mem_addr) != rd_cnt) addr_err++;
        rd_last_addr = int'(bus.mem_addr);
        rd_cnt++;
      end
      if (bus.start) begin
        if (st_cnt < 32) st_cyc[st_cnt] = cyc - cyc0;
        if (st_cnt == 0) begin
          first_p1 = bus.p1; first_p2 = bus.p2; first_p3 = bus.p3;
        end
        if ({bus.p3, bus.p2, bus.p1} !== exp_tri(st_cnt)) pm_err++;
        st_cnt++;
        cd = rast_delay;
      end else begin
        if (bus.p1 !== pp1 || bus.p2 !== pp2 || bus.p3 !== pp3) p_err++;
        if (cd > 0) begin
          cd--;
          if (cd == 0) done_auto = 1'b1;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc  = cyc - cyc0;
        fd_busy = busy;
      end
      if (busy) busy_cnt++;
    end
    pp1 = bus.p1; pp2 = bus.p2; pp3 = bus.p3;
  end

  task automatic pulse_fs(input int n);
    @(posedge clk); #1;
    tri_count   = CNT_W'(n);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic fstart(input int n);
    @(posedge clk); #1;
    clr_mon();
    tri_count   = CNT_W'(n);
    frame_start = 1'b1;
    cyc0        = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string tag);
    int i = 0;
    while (fd_cnt < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (fd_cnt < target) chk({tag, "_fd_timeout"}, fd_cnt, target);
    @(negedge clk);
  endtask

  task automatic wait_st(input int target, input int budget, input string tag);
    int i = 0;
    while (st_cnt < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (st_cnt < target) chk({tag, "_start_timeout"}, st_cnt, target);
  endtask

  initial begin
    for (int i = 0; i < int'(MAX_TRIS*WORDS_PER_TRI); i++) ram[i] = 32'h4100_0000 + i;
    ram[0] = 32'h428a0000; ram[1] = 32'h428a0000; ram[2] = FP_ONE;
    ram[3] = 32'h43290000; ram[4] = 32'h428a0000; ram[5] = FP_ONE;
    ram[6] = 32'h428a0000; ram[7] = 32'h43290000; ram[8] = FP_ONE;
    clr_mon();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_p", {bus.p3, bus.p2, bus.p1}, 0);
    areset = 1'b0;
    repeat (2) @(posedge clk);

    // single triangle, done 20 cycles after start
    raster_auto = 1'b1; rast_delay = 20;
    fstart(1);
    wait_fd(1, 200, "t1");
    chk("t1_rd_cnt", rd_cnt, 9);
    chk("t1_rd_first_cyc", rd_first_cyc, 1);
    chk("t1_rd_last_addr", rd_last_addr, 8);
    chk("t1_addr_seq", addr_err, 0);
    chk("t1_starts", st_cnt, 1);
    chk("t1_start_cyc", st_cyc[0], 12);
    chk("t1_p1", first_p1, {32'h3f800000, 32'h428a0000, 32'h428a0000});
    chk("t1_p2", first_p2, {32'h3f800000, 32'h428a0000, 32'h43290000});
    chk("t1_p3", first_p3, {32'h3f800000, 32'h43290000, 32'h428a0000});
    chk("t1_fd_cyc", fd_cyc, 33);
    chk("t1_fd_busy", fd_busy, 0);
    chk("t1_busy_cycles", busy_cnt, 32);

    // three triangles, done 50 cycles after each start
    rast_delay = 50;
    fstart(3);
    wait_fd(1, 600, "t3");
    repeat (5) @(negedge clk);
    chk("t3_starts", st_cnt, 3);
    chk("t3_start1_cyc", st_cyc[0], 12);
    chk("t3_start2_cyc", st_cyc[1], 64);
    chk("t3_start3_cyc", st_cyc[2], 116);
    chk("t3_prefetch_cyc", rd9_cyc, 12);
    chk("t3_rd_cnt", rd_cnt, 27);
    chk("t3_addr_seq", addr_err, 0);
    chk("t3_p_match", pm_err, 0);
    chk("t3_p_stable", p_err, 0);
    chk("t3_fd_cnt", fd_cnt, 1);
    chk("t3_fd_cyc", fd_cyc, 167);

    // done held high across the frame
    raster_auto = 1'b0; done_man = 1'b1;
    repeat (3) @(posedge clk);
    fstart(2);
    wait_st(1, 100, "hh");
    repeat (30) @(negedge clk);
    chk("hh_held_starts", st_cnt, 1);
    chk("hh_held_busy", busy, 1);
    @(negedge clk) done_man = 1'b0;
    @(negedge clk) done_man = 1'b1;
    repeat (10) @(negedge clk);
    chk("hh_rise1_starts", st_cnt, 2);
    chk("hh_rise1_fd", fd_cnt, 0);
    repeat (30) @(negedge clk);
    chk("hh_held2_fd", fd_cnt, 0);
    @(negedge clk) done_man = 1'b0;
    @(negedge clk) done_man = 1'b1;
    wait_fd(1, 20, "hh");
    chk("hh_fd_cnt", fd_cnt, 1);
    chk("hh_p_match", pm_err, 0);
    @(negedge clk) done_man = 1'b0;
    raster_auto = 1'b1;
    repeat (3) @(posedge clk);

    // empty frame
    fstart(0);
    repeat (5) @(negedge clk);
    chk("z_fd_cnt", fd_cnt, 1);
    chk("z_fd_cyc", fd_cyc, 1);
    chk("z_rd_cnt", rd_cnt, 0);
    chk("z_starts", st_cnt, 0);
    chk("z_busy_cycles", busy_cnt, 0);

    // oversized count clamps to MAX_TRIS
    rast_delay = 3;
    fstart(31);
    wait_fd(1, 3000, "c");
    chk("c_starts", st_cnt, 16);
    chk("c_rd_cnt", rd_cnt, 144);
    chk("c_rd_last_addr", rd_last_addr, 143);
    chk("c_addr_seq", addr_err, 0);
    chk("c_p_match", pm_err, 0);

    // frame_start while busy is ignored
    rast_delay = 30;
    fstart(2);
    wait_st(1, 100, "ig");
    pulse_fs(5);
    wait_fd(1, 500, "ig");
    repeat (50) @(negedge clk);
    chk("ig_starts", st_cnt, 2);
    chk("ig_rd_cnt", rd_cnt, 18);
    chk("ig_addr_seq", addr_err, 0);
    chk("ig_fd_cnt", fd_cnt, 1);
    chk("ig_busy_after", busy, 0);

    // reset during L_WAIT of triangle 2 of 4
    rast_delay = 40;
    fstart(4);
    wait_st(2, 300, "r");
    repeat (5) @(posedge clk);
    #2 areset = 1'b1;
    #1;
    chk("r_mem_rd", bus.mem_rd, 0);
    chk("r_mem_addr", bus.mem_addr, 0);
    chk("r_start", bus.start, 0);
    chk("r_busy", busy, 0);
    chk("r_frame_done", frame_done, 0);
    chk("r_p", {bus.p3, bus.p2, bus.p1}, 0);
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    repeat (100) @(negedge clk);
    chk("r_no_fd", fd_cnt, 0);
    rast_delay = 10;
    fstart(1);
    wait_fd(1, 200, "r2");
    chk("r2_rd_first_cyc", rd_first_cyc, 1);
    chk("r2_rd_cnt", rd_cnt, 9);
    chk("r2_addr_seq", addr_err, 0);
    chk("r2_starts", st_cnt, 1);
    chk("r2_p_match", pm_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/triangle_dispatcher.md
Name: triangle_dispatcher

Overview:
- Upstream feeder for rasterizer_unit. It walks a triangle list in vertex RAM (9 float32 words per triangle: x1,y1,z1,x2,y2,z2,x3,y3,z3) and loads p1/p2/p3.
- It pulses start and waits for the rasterizer's done before issuing the next triangle.
- A one-entry staging buffer prefetches the next triangle while the current one rasterizes. Runs on the gpu_clk_150 domain.

Parameters:
- MAX_TRIS, 16, maximum triangles per frame.
- MEM_AW, $clog2(MAX_TRIS*9), vertex RAM address width.
- CNT_W, $clog2(MAX_TRIS+1), width of tri_count.

Ports:
- clk  in  1  gpu clock (gpu_clk_150).
- areset  in  1  asynchronous reset, active-high.
- frame_start  in  1  single-cycle pulse that begins dispatch of one frame.
- tri_count  in  CNT_W  triangles in the frame; latched on an accepted frame_start.
- mem_rd  out  1  vertex RAM read strobe.
- mem_addr  out  MEM_AW  vertex RAM word address.
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd.
- p1, p2, p3  out  32 x [3] each  vertex {x,y,z} float32 to rasterizer_unit.
- start  out  1  single-cycle launch pulse to rasterizer_unit.
- done  in  1  rasterizer completion level.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  single-cycle pulse when the last triangle completes.

Behaviour:
- Reset (async, areset=1): p1/p2/p3=0, start=0, mem_rd=0, mem_addr=0, busy=0, frame_done=0. Staging buffer is invalid, all counters are 0, FSMs are IDLE. Reset mid-frame abandons the frame; there is no frame_done.
- frame_start while busy=1 is ignored. The tri_count it carries is not latched.
- tri_count > MAX_TRIS is clamped to MAX_TRIS. tri_count=0 gives frame_done=1 on the next cycle, with no reads, no start, and busy staying 0.
- Fetch engine (states F_IDLE, F_READ, F_FILL):
  - It starts a fetch when stg_valid=0 and fetch_remaining>0.
  - It issues mem_rd for 9 consecutive cycles at incrementing addresses, using a running address counter with no multiply. Triangle n occupies words 9n..9n+8.
  - Word k returns the following cycle into staging[k]. stg_valid is set on the edge capturing word 8, and fetch_remaining is decremented there.
  - The address counter is reset to 0 on frame_start.
- Launch engine (states L_IDLE, L_LAUNCH, L_WAIT, L_FINISH):
  - L_IDLE: when stg_valid=1 and the rasterizer is free, copy staging to p1/p2/p3, clear stg_valid, and go to L_LAUNCH.
  - L_LAUNCH: start=1 for exactly one cycle, then L_WAIT.
  - L_WAIT: completion is the rising edge of done (done & ~done_q). A done level held high from a prior triangle must not complete the wait.
  - On completion, if launch_remaining>0 go to L_IDLE, else go to L_FINISH.
  - L_FINISH: frame_done=1 for one cycle, busy=0 on the same cycle, then L_IDLE.
- The fetch engine may run while the launch engine is in L_WAIT (prefetch). If stg_valid clears and a fetch could restart in the same cycle, the fetch starts on the following cycle.
- p1/p2/p3 change only on the L_IDLE to L_LAUNCH copy. They are stable through L_WAIT.
- Latency, tri_count≥1, frame_start in cycle 0: mem_rd high in cycles 1–9, addresses 0..8. Staging is valid after cycle 10. p outputs update and start=1 in cycle 12. Triangle 2's mem_rd begins in cycle 12.
- busy=1 from the cycle after an accepted frame_start until the frame_done cycle.

Decomposition:
- gpu_pkg holds:
  - WORDS_PER_TRI=9.
  - typedef vertex_t as logic [31:0] [3].
  - FP_ONE=32'h3f800000.
  - The launch-FSM enum.
  - This package is shared with rasterizer_unit.
- Sub-module tri_fetch_unit: owns the address counter, the 9-word read sequence, the staging buffer and stg_valid. It exposes a stg_valid/stg_take handshake plus staged vertices.

Test Plan:
- Single triangle, RAM words 0..8 = 428a0000,428a0000,3f800000,43290000,428a0000,3f800000,428a0000,43290000,3f800000, tri_count=1:
  - mem_rd on cycles 1–9 at addresses 0..8.
  - start pulse on cycle 12 with p1={428a0000,428a0000,3f800000}, p2={43290000,428a0000,3f800000}, p3={428a0000,43290000,3f800000}.
  - done rising 20 cycles later -> frame_done one cycle after, busy low.
- tri_count=3 with done delayed 50 cycles per triangle:
  - The second fetch (addresses 9..17) completes during the first L_WAIT.
  - Exactly 3 start pulses, each with p values matching RAM, and p stable between starts.
  - One frame_done.
- done held high continuously from before the frame -> no triangle completes until done drops and rises again. Exactly one completion per rising edge.
- tri_count=0 -> frame_done on the next cycle, no mem_rd, no start. tri_count=31 -> exactly 16 starts, last address 143.
- frame_start pulsed again mid-frame with tri_count=5 -> ignored; the original count of triangles completes.
- areset asserted during L_WAIT of triangle 2 of 4 -> all outputs 0 immediately, no frame_done. A new frame_start with tri_count=1 after release reads from address 0.
